// File: rtl/prog_ctr_stack.sv
// Fetch-stage program counter with a hardware return-address stack.
// Optional macro PROGCTR_FAULT_EN: stack overflow/underflow freezes fetch.
module prog_ctr_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Stall,
    input  logic                       BranchRel,
    input  logic                       Zero,
    input  logic                       Jump,
    input  logic                       Call,
    input  logic                       Ret,
    input  logic [W-1:0]               Target,
    output logic [W-1:0]               PC,
    output logic [$clog2(DEPTH+1)-1:0] Depth,
    output logic                       Full,
    output logic                       Empty,
    output logic                       Fault
);

    localparam int DW = $clog2(DEPTH+1);

    logic [W-1:0]            pc_q, pc_d;
    logic [DW-1:0]           depth_q, depth_d;
    logic                    fault_q, fault_d;
    logic [DEPTH-1:0][W-1:0] stk_q, stk_d;

    logic [W-1:0]  pc_inc;
    logic [W-1:0]  top;
    logic          full;
    logic          empty;
    logic [DW-1:0] depth_m1;

    assign pc_inc   = pc_q + W'(1);
    assign full     = (depth_q == DW'(DEPTH));
    assign empty    = (depth_q == '0);
    assign depth_m1 = depth_q - DW'(1);

    // Select the top-of-stack entry (entry Depth-1).
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (DW'(i) == depth_m1) begin
                top = stk_q[i];
            end
        end
    end

    // Prioritised next-state selection: fault, stall, ret, call, jump, branch, increment.
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        fault_d = fault_q;
        stk_d   = stk_q;
        if (fault_q || Stall) begin
            pc_d = pc_q;
        end else if (Ret) begin
            if (!empty) begin
                pc_d    = top;
                depth_d = depth_m1;
            end else begin
`ifdef PROGCTR_FAULT_EN
                fault_d = 1'b1;
`else
                pc_d = pc_inc;
`endif
            end
        end else if (Call) begin
            if (!full) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (DW'(i) == depth_q) begin
                        stk_d[i] = pc_inc;
                    end
                end
                depth_d = depth_q + DW'(1);
                pc_d    = Target;
            end else begin
`ifdef PROGCTR_FAULT_EN
                fault_d = 1'b1;
`else
                pc_d = Target;
`endif
            end
        end else if (Jump) begin
            pc_d = Target;
        end else if (BranchRel && !Zero) begin
            if (Target[W-1]) begin
                pc_d = pc_q - {1'b0, Target[W-2:0]};
            end else begin
                pc_d = pc_q + Target;
            end
        end else begin
            pc_d = pc_inc;
        end
    end

    // Register PC, stack, depth and sticky fault; reset wins over everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q    <= '0;
            depth_q <= '0;
            fault_q <= 1'b0;
            stk_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            fault_q <= fault_d;
            stk_q   <= stk_d;
        end
    end

    assign PC    = pc_q;
    assign Depth = depth_q;
    assign Full  = full;
    assign Empty = empty;
    assign Fault = fault_q;

endmodule
